// File: rtl/pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, fixed instruction words and the
// hazard-controller state encoding.
package pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_IW    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    // I/R/S/B formats carry a real rs1 field; U/J formats reuse those bits as immediate.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM,
            OP_OP, OP_STORE, OP_BRANCH:           return 1'b1;
            OP_LUI, OP_AUIPC, OP_JAL:             return 1'b0;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OP_OP, OP_STORE, OP_BRANCH: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID, which
// cannot be covered by EX forwarding and needs a one-cycle stall.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [31:0] id_iw,
    input  logic [31:0] ex_iw,
    input  logic [4:0]  ex_wb_reg,
    input  logic        ex_wb_enable,
    output logic        lu_hazard
);

    logic [6:0] id_op;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       ex_is_load;
    logic       unused_ok;

    assign id_op      = id_iw[6:0];
    assign id_rs1     = id_iw[19:15];
    assign id_rs2     = id_iw[24:20];
    assign ex_is_load = (ex_iw[6:0] == OP_LOAD) && ex_wb_enable && (ex_wb_reg != 5'd0);
    assign unused_ok  = ^{id_iw[31:25], id_iw[14:7], ex_iw[31:7]};

    assign lu_hazard = ex_is_load &&
                       ((uses_rs1(id_op) && (id_rs1 == ex_wb_reg)) ||
                        (uses_rs2(id_op) && (id_rs2 == ex_wb_reg)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencing for the 5-stage pipeline around EX, with
// saturating stall and flush cycle counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_iw,
    input  logic [31:0]      ex_iw,
    input  logic [4:0]       ex_wb_reg,
    input  logic             ex_wb_enable,
    input  logic             branch_taken,
    input  logic             resume,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int             FC_W         = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    ctrl_state_t     state;
    logic [FC_W-1:0] flush_left;
    logic            lu_hazard;
    logic            ebreak_ex;
    logic            lu_win;

    load_use_detect u_lud (
        .id_iw        (id_iw),
        .ex_iw        (ex_iw),
        .ex_wb_reg    (ex_wb_reg),
        .ex_wb_enable (ex_wb_enable),
        .lu_hazard    (lu_hazard)
    );

    assign ebreak_ex = (ex_iw == EBREAK_IW);
    assign lu_win    = reset && (state == RUN) && !ebreak_ex && !branch_taken && lu_hazard;

    // Controls are zero-latency decodes of state and inputs, forced low while in reset.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        halted    = 1'b0;
        if (reset) begin
            unique case (state)
                RUN: begin
                    if (ebreak_ex || (!branch_taken && lu_hazard)) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (branch_taken) begin
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                FLUSH: begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                HALT: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    halted    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            flush_left <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ebreak_ex) begin
                        state <= HALT;
                    end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
                        state      <= FLUSH;
                        flush_left <= FLUSH_RELOAD;
                    end
                end
                FLUSH: begin
                    if (ebreak_ex) begin
                        state <= HALT;
                    end else if (branch_taken) begin
                        flush_left <= FLUSH_RELOAD;
                    end else if (flush_left <= FC_W'(1)) begin
                        state <= RUN;
                    end else begin
                        flush_left <= flush_left - FC_W'(1);
                    end
                end
                HALT: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Performance counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_win && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_id && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected controls/counters are queued
// per cycle and compared mid-cycle against a 32-bit and a 4-bit counter instance.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam logic [31:0] LW_X5   = 32'h0000_A283;
    localparam logic [31:0] LW_X0   = 32'h0000_A003;
    localparam logic [31:0] ADD_DEP = 32'h0022_8333;
    localparam logic [31:0] ADD_RS2 = 32'h0051_0333;
    localparam logic [31:0] SW_DEP  = 32'h0051_2023;
    localparam logic [31:0] LUI_X5  = 32'h0000_12B7;
    localparam logic [31:0] ADDI_ND = 32'h0013_8313;

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11100;
    localparam logic [4:0] C_FLUSH = 5'b00110;
    localparam logic [4:0] C_HALT  = 5'b11101;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_iw, ex_iw;
    logic [4:0]  ex_wb_reg;
    logic        ex_wb_enable, branch_taken, resume;
    logic        stall_if, stall_id, bubble_ex, flush_id, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_stall_if, s_stall_id, s_bubble_ex, s_flush_id, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    typedef struct {
        string       tag;
        logic [4:0]  ctrl;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_iw(id_iw), .ex_iw(ex_iw),
        .ex_wb_reg(ex_wb_reg), .ex_wb_enable(ex_wb_enable),
        .branch_taken(branch_taken), .resume(resume),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_id(flush_id), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .id_iw(id_iw), .ex_iw(ex_iw),
        .ex_wb_reg(ex_wb_reg), .ex_wb_enable(ex_wb_enable),
        .branch_taken(branch_taken), .resume(resume),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .bubble_ex(s_bubble_ex),
        .flush_id(s_flush_id), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic apply_stimulus(input string tag, input logic rst,
                                  input logic [31:0] id, input logic [31:0] ex,
                                  input logic [4:0] wbreg, input logic wben,
                                  input logic br, input logic res,
                                  input logic [4:0] ctrl, input int scnt, input int fcnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        id_iw        = id;
        ex_iw        = ex;
        ex_wb_reg    = wbreg;
        ex_wb_enable = wben;
        branch_taken = br;
        resume       = res;
        e.tag  = tag;
        e.ctrl = ctrl;
        e.scnt = 32'(scnt);
        e.fcnt = 32'(fcnt);
        sb.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        logic [4:0] obs;
        logic [4:0] obs_s;
        logic [3:0] exp_s4;
        logic [3:0] exp_f4;
        obs    = {stall_if, stall_id, bubble_ex, flush_id, halted};
        obs_s  = {s_stall_if, s_stall_id, s_bubble_ex, s_flush_id, s_halted};
        exp_s4 = (e.scnt > 32'd15) ? 4'hF : e.scnt[3:0];
        exp_f4 = (e.fcnt > 32'd15) ? 4'hF : e.fcnt[3:0];
        n_total++;
        assert (obs === e.ctrl) n_pass++;
        else $error("[TB] FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.ctrl);
        n_total++;
        assert (stall_cnt === e.scnt) n_pass++;
        else $error("[TB] FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.scnt);
        n_total++;
        assert (flush_cnt === e.fcnt) n_pass++;
        else $error("[TB] FAIL %s flush_cnt observed=%0d expected=%0d", e.tag, flush_cnt, e.fcnt);
        n_total++;
        assert (obs_s === e.ctrl) n_pass++;
        else $error("[TB] FAIL %s small ctrl observed=%b expected=%b", e.tag, obs_s, e.ctrl);
        n_total++;
        assert (s_stall_cnt === exp_s4) n_pass++;
        else $error("[TB] FAIL %s small stall_cnt observed=%0d expected=%0d", e.tag, s_stall_cnt, exp_s4);
        n_total++;
        assert (s_flush_cnt === exp_f4) n_pass++;
        else $error("[TB] FAIL %s small flush_cnt observed=%0d expected=%0d", e.tag, s_flush_cnt, exp_f4);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            check_output(sb.pop_front());
        end
    end

    initial begin
        reset        = 1'b1;
        id_iw        = NOP_IW;
        ex_iw        = NOP_IW;
        ex_wb_reg    = 5'd0;
        ex_wb_enable = 1'b0;
        branch_taken = 1'b0;
        resume       = 1'b0;
        #2 reset = 1'b0;

        // Reset held with hazard and branch driven: everything stays low.
        apply_stimulus("in_reset",  0, ADD_DEP, LW_X5, 5, 1, 1, 0, C_IDLE, 0, 0);
        apply_stimulus("idle",      1, NOP_IW,  NOP_IW, 0, 0, 0, 0, C_IDLE, 0, 0);

        // Load-use detection.
        apply_stimulus("lu_rs1",    1, ADD_DEP, LW_X5,  5, 1, 0, 0, C_STALL, 0, 0);
        apply_stimulus("lu_after",  1, ADD_DEP, NOP_IW, 0, 0, 0, 0, C_IDLE,  1, 0);
        apply_stimulus("lu_store",  1, SW_DEP,  LW_X5,  5, 1, 0, 0, C_STALL, 1, 0);
        apply_stimulus("lu_rs2",    1, ADD_RS2, LW_X5,  5, 1, 0, 0, C_STALL, 2, 0);
        apply_stimulus("lu_idle",   1, NOP_IW,  NOP_IW, 0, 0, 0, 0, C_IDLE,  3, 0);
        apply_stimulus("lui_nohz",  1, LUI_X5,  LW_X5,  5, 1, 0, 0, C_IDLE,  3, 0);
        apply_stimulus("x0_nohz",   1, ADD_DEP, LW_X0,  0, 1, 0, 0, C_IDLE,  3, 0);
        apply_stimulus("rs1_other", 1, ADDI_ND, LW_X5,  5, 1, 0, 0, C_IDLE,  3, 0);
        apply_stimulus("no_wben",   1, ADD_DEP, LW_X5,  5, 0, 0, 0, C_IDLE,  3, 0);

        // Single redirect: two flush cycles.
        apply_stimulus("br1_c1",    1, NOP_IW, NOP_IW, 0, 0, 1, 0, C_FLUSH, 3, 0);
        apply_stimulus("br1_c2",    1, NOP_IW, NOP_IW, 0, 0, 0, 0, C_FLUSH, 3, 1);
        apply_stimulus("br1_done",  1, NOP_IW, NOP_IW, 0, 0, 0, 0, C_IDLE,  3, 2);

        // Second redirect during FLUSH stretches it to three cycles.
        apply_stimulus("br2_c1",    1, NOP_IW, NOP_IW, 0, 0, 1, 0, C_FLUSH, 3, 2);
        apply_stimulus("br2_c2",    1, NOP_IW, NOP_IW, 0, 0, 1, 0, C_FLUSH, 3, 3);
        apply_stimulus("br2_c3",    1, NOP_IW, NOP_IW, 0, 0, 0, 0, C_FLUSH, 3, 4);
        apply_stimulus("br2_done",  1, NOP_IW, NOP_IW, 0, 0, 0, 0, C_IDLE,  3, 5);

        // Redirect beats a simultaneous load-use hazard.
        apply_stimulus("br_lu_c1",  1, ADD_DEP, LW_X5,  5, 1, 1, 0, C_FLUSH, 3, 5);
        apply_stimulus("br_lu_c2",  1, ADD_DEP, LW_X5,  5, 1, 0, 0, C_FLUSH, 3, 6);
        apply_stimulus("br_lu_end", 1, NOP_IW,  NOP_IW, 0, 0, 0, 0, C_IDLE,  3, 7);

        // EBREAK halts; branch ignored while halted; resume releases one cycle later.
        apply_stimulus("ebreak",    1, NOP_IW, EBREAK_IW, 0, 0, 0, 0, C_STALL, 3, 7);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus("halt_hold", 1, NOP_IW, NOP_IW, 0, 0, (i == 3), 0, C_HALT, 3, 7);
        end
        apply_stimulus("resume",    1, NOP_IW, NOP_IW, 0, 0, 0, 1, C_HALT,  3, 7);
        apply_stimulus("resumed",   1, NOP_IW, NOP_IW, 0, 0, 0, 0, C_IDLE,  3, 7);
        apply_stimulus("resume_run",1, NOP_IW, NOP_IW, 0, 0, 0, 1, C_IDLE,  3, 7);

        // Reset in the middle of FLUSH.
        apply_stimulus("pre_rst_fl",1, NOP_IW, NOP_IW, 0, 0, 1, 0, C_FLUSH, 3, 7);
        apply_stimulus("rst_flush", 0, NOP_IW, NOP_IW, 0, 0, 0, 0, C_IDLE,  0, 0);
        apply_stimulus("post_rst1", 1, NOP_IW, NOP_IW, 0, 0, 0, 0, C_IDLE,  0, 0);
        apply_stimulus("post_rst_lu",1, ADD_DEP, LW_X5, 5, 1, 0, 0, C_STALL, 0, 0);

        // Reset in the middle of HALT.
        apply_stimulus("pre_rst_h", 1, NOP_IW, EBREAK_IW, 0, 0, 0, 0, C_STALL, 1, 0);
        apply_stimulus("halt_b4rst",1, NOP_IW, NOP_IW,    0, 0, 0, 0, C_HALT,  1, 0);
        apply_stimulus("rst_halt",  0, NOP_IW, NOP_IW,    0, 0, 0, 0, C_IDLE,  0, 0);
        apply_stimulus("post_rst2", 1, NOP_IW, NOP_IW,    0, 0, 0, 0, C_IDLE,  0, 0);

        // Back-to-back hazards: the 4-bit instance saturates at 4'hF.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus("sat_run", 1, ADD_DEP, LW_X5, 5, 1, 0, 0, C_STALL, i, 0);
        end
        apply_stimulus("sat_final", 1, NOP_IW, NOP_IW, 0, 0, 0, 0, C_IDLE, 20, 0);

        @(posedge clk);
        #1;
        n_total++;
        assert (sb.size() == 0) n_pass++;
        else $error("[TB] FAIL drain pending observed=%0d expected=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
